mem_stage: RTL and testbench
============================

Name: mem_stage

Overview:
- Memory stage of the RV32I 5-stage pipeline. Sits directly downstream of the execute stage and consumes its M-register outputs.
- Issues loads and stores to data memory over a req/ack handshake. Aligns store data into byte lanes and sign/zero-extends load data.
- Selects the writeback result and registers everything into the W pipeline register.
- Stalls the pipeline while memory is busy, and aborts with an error on misalignment or timeout.

Parameters:
- TIMEOUT, 16: maximum cycles to wait for dmem_ack before aborting the access.
- CNT_W, 5: width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- regWrite_M  in  1  instruction writes rd.
- memWrite_M  in  1  store.
- memRead_M  in  1  load.
- resultScr_M  in  3  writeback select: 000 ALU, 001 load data, 010 pc+4, 011 imm, 100 PC target.
- mode_M  in  3  funct3 size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU.
- ALUResult_M  in  32  ALU result; also the memory address.
- write_Data_M  in  32  store source (rs2).
- imm_extended_M  in  32  immediate (LUI).
- PC_target_M  in  32  pc+imm (AUIPC).
- pc4_M  in  32  pc+4 (JAL/JALR link).
- rd_M  in  5  destination register.
- dmem_req  out  1  access request.
- dmem_we  out  1  1 = write.
- dmem_addr  out  32  word-aligned address, {ALUResult_M[31:2],2'b00}.
- dmem_be  out  4  byte enables.
- dmem_wdata  out  32  lane-aligned store data.
- dmem_rdata  in  32  read word; valid when dmem_ack is high.
- dmem_ack  in  1  access complete.
- stall_M  out  1  hold IF/ID/EX/M registers.
- mem_err  out  1  one-cycle pulse on misalignment or timeout.
- regWrite_W  out  1  registered.
- rd_W  out  5  registered.
- result_W  out  32  registered writeback value.

Behaviour:

Access detection:
- access = memRead_M | memWrite_M.
- misaligned = (H/HU and addr[0]) or (W and addr[1:0]!=0).
- If both memRead_M and memWrite_M are high, treat the access as a store.

Byte enables and store data:
- B/BU: be = 0001 << addr[1:0].
- H/HU: be = 0011 << addr[1:0].
- W: be = 1111.
- Store data: SB replicates byte[7:0] to all 4 lanes; SH replicates half[15:0] to both halves; SW passes the word through.

Load extraction:
- Select the byte/half from dmem_rdata using addr[1:0].
- B and H sign-extend; BU and HU zero-extend.
- Undefined mode on a load yields the full word.

FSM states:
- IDLE:
  - If access and not misaligned: dmem_req=1 combinationally.
  - If dmem_ack the same cycle, complete with no stall.
  - Otherwise stall_M=1, counter=1, go to WAIT.
- WAIT:
  - dmem_req, dmem_we, dmem_be, dmem_addr and dmem_wdata stay asserted and stable. Upstream holds the M inputs because stall_M=1.
  - stall_M=1 while waiting.
  - On dmem_ack: stall_M=0 this cycle, go to IDLE, instruction completes.
  - If counter==TIMEOUT and no ack: drop req, mem_err=1, go to IDLE, instruction completes with regWrite_W forced 0.
  - Counter increments by 1 each WAIT cycle.
- Misaligned access in IDLE:
  - No request issued, no stall.
  - mem_err=1, regWrite_W forced 0.
- Non-memory instruction: no req, no stall, passes straight to W.

W register (one-cycle latency M→W):
- On each edge where the instruction completes:
  - regWrite_W = regWrite_M & ~error.
  - rd_W = rd_M.
  - result_W = the resultScr-selected value; load data is taken from the acked dmem_rdata.
- On edges where stall_M=1: insert a bubble, regWrite_W=0; rd_W and result_W hold.

Reset:
- All outputs 0; FSM in IDLE; counter 0.
- Reset asserted during WAIT drops dmem_req immediately (asynchronous).

Fixed decisions:
- mem_err is combinational from state, one pulse per faulting instruction.
- Reserved resultScr codes (101–111) select the ALU result.
- The wait counter saturates at TIMEOUT.

Test Plan:
1. LW, addr 0x100, ack in same cycle, rdata 0xDEADBEEF, rd=5 → no stall; next cycle regWrite_W=1, rd_W=5, result_W=0xDEADBEEF.
2. LB at addr 0x103 with rdata 0x80FF_0000 → result_W=0xFFFFFF80. LBU at the same address → 0x00000080. LHU at 0x102 → 0x000080FF.
3. SB, addr 0x102, rs2=0x12345678, ack after 3 cycles → dmem_be=0100, dmem_wdata=0x78787878, stall_M high for exactly 3 cycles with outputs stable, then 3 bubbles with regWrite_W=0.
4. LH at 0x101 → no dmem_req, mem_err pulses 1 cycle, regWrite_W=0, no stall.
5. LW with dmem_ack never asserted, TIMEOUT=16 → stall for 16 cycles, mem_err pulse, req drops, regWrite_W=0; the next instruction proceeds normally.
6. JAL (resultScr=010, pc4=0x24) then AUIPC (resultScr=100, target=0x1020) → result_W=0x24, then 0x1020, no req. Assert rst mid-WAIT → req, stall and all outputs go to 0 immediately.

Source files
------------

// File: rtl/mem_stage_if.sv
// Data-memory bus between the memory stage and data memory.
// Handshake: the master raises req with we/addr/be/wdata and holds them
// stable until the cycle where the slave raises ack. rdata is only
// meaningful in that ack cycle. The master may withdraw req without an ack
// only when it abandons the access on timeout.
interface mem_stage_if;
   logic        req;
   logic        we;
   logic [31:0] addr;
   logic [3:0]  be;
   logic [31:0] wdata;
   logic [31:0] rdata;
   logic        ack;

   modport master (output req, output we, output addr, output be, output wdata,
                   input rdata, input ack);
   modport slave  (input req, input we, input addr, input be, input wdata,
                   output rdata, output ack);
endinterface

// File: rtl/mem_stage.sv
// RV32I memory stage: issues loads/stores over the data-memory handshake,
// lane-aligns store data, extends load data, selects the writeback value
// and registers it into the W pipeline register. Stalls while memory is
// busy and aborts on misalignment or ack timeout.
module mem_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        regWrite_M,
   input  logic        memWrite_M,
   input  logic        memRead_M,
   input  logic [2:0]  resultScr_M,
   input  logic [2:0]  mode_M,
   input  logic [31:0] ALUResult_M,
   input  logic [31:0] write_Data_M,
   input  logic [31:0] imm_extended_M,
   input  logic [31:0] PC_target_M,
   input  logic [31:0] pc4_M,
   input  logic [4:0]  rd_M,
   mem_stage_if.master dmem,
   output logic        stall_M,
   output logic        mem_err,
   output logic        regWrite_W,
   output logic [4:0]  rd_W,
   output logic [31:0] result_W,
   output logic        dbg_state
);

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [CNT_W-1:0] TO_CNT = CNT_W'(TIMEOUT);

   state_t           state, state_next;
   logic [CNT_W-1:0] cnt, cnt_next;
   logic             req_c, stall_c, err_c;
   logic             access, misaligned;
   logic [1:0]       lo;
   logic [3:0]       be_c;
   logic [31:0]      wdata_c;
   logic [31:0]      shifted;
   logic [7:0]       ld_byte;
   logic [15:0]      ld_half;
   logic [31:0]      load_val;
   logic [31:0]      result_sel;

   assign dbg_state = state;

   // Address decode, byte enables and store-lane replication
   always_comb begin
      lo         = ALUResult_M[1:0];
      access     = memRead_M | memWrite_M;
      misaligned = 1'b0;
      be_c       = 4'b1111;
      wdata_c    = write_Data_M;
      case (mode_M)
         3'b000, 3'b100: be_c = 4'b0001 << lo;
         3'b001, 3'b101: begin
            be_c       = 4'b0011 << lo;
            misaligned = lo[0];
         end
         3'b010: misaligned = (lo != 2'b00);
         default: be_c = 4'b1111;
      endcase
      case (mode_M[1:0])
         2'b00:   wdata_c = {4{write_Data_M[7:0]}};
         2'b01:   wdata_c = {2{write_Data_M[15:0]}};
         default: wdata_c = write_Data_M;
      endcase
   end

   // Load extraction from the returned word
   always_comb begin
      shifted  = dmem.rdata >> {lo, 3'b000};
      ld_byte  = shifted[7:0];
      ld_half  = lo[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
      load_val = dmem.rdata;
      case (mode_M)
         3'b000:  load_val = {{24{ld_byte[7]}}, ld_byte};
         3'b100:  load_val = {24'h0, ld_byte};
         3'b001:  load_val = {{16{ld_half[15]}}, ld_half};
         3'b101:  load_val = {16'h0, ld_half};
         default: load_val = dmem.rdata;
      endcase
   end

   // Writeback source select; reserved codes fall back to the ALU result
   always_comb begin
      case (resultScr_M)
         3'b001:  result_sel = load_val;
         3'b010:  result_sel = pc4_M;
         3'b011:  result_sel = imm_extended_M;
         3'b100:  result_sel = PC_target_M;
         default: result_sel = ALUResult_M;
      endcase
   end

   // Access FSM: next state, wait counter, request/stall/error
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      req_c      = 1'b0;
      stall_c    = 1'b0;
      err_c      = 1'b0;
      case (state)
         IDLE: begin
            if (access) begin
               if (misaligned) begin
                  err_c = 1'b1;
               end else begin
                  req_c = 1'b1;
                  if (!dmem.ack) begin
                     stall_c    = 1'b1;
                     cnt_next   = CNT_W'(1);
                     state_next = WAIT;
                  end
               end
            end
         end
         WAIT: begin
            if (dmem.ack) begin
               req_c      = 1'b1;
               cnt_next   = '0;
               state_next = IDLE;
            end else if (cnt == TO_CNT) begin
               // Give up: request withdrawn, instruction retires without write
               err_c      = 1'b1;
               cnt_next   = '0;
               state_next = IDLE;
            end else begin
               req_c    = 1'b1;
               stall_c  = 1'b1;
               cnt_next = cnt + CNT_W'(1);
            end
         end
         default: state_next = IDLE;
      endcase
   end

   // Bus and control outputs; reset forces them low without waiting for a clock
   always_comb begin
      dmem.req   = req_c & ~rst;
      dmem.we    = dmem.req & memWrite_M;
      dmem.addr  = dmem.req ? {ALUResult_M[31:2], 2'b00} : 32'h0;
      dmem.be    = dmem.req ? be_c : 4'h0;
      dmem.wdata = (dmem.req & memWrite_M) ? wdata_c : 32'h0;
      stall_M    = stall_c & ~rst;
      mem_err    = err_c & ~rst;
   end

   // FSM state and wait counter
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
      end
   end

   // W pipeline register: bubble while stalled, else capture the instruction
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regWrite_W <= 1'b0;
         rd_W       <= '0;
         result_W   <= '0;
      end else if (stall_c) begin
         regWrite_W <= 1'b0;
      end else begin
         regWrite_W <= regWrite_M & ~err_c;
         rd_W       <= rd_M;
         result_W   <= result_sel;
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: loads, stores, misalignment, timeout,
// writeback selection and asynchronous reset during a wait.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        regWrite_M, memWrite_M, memRead_M;
   logic [2:0]  resultScr_M, mode_M;
   logic [31:0] ALUResult_M, write_Data_M, imm_extended_M, PC_target_M, pc4_M;
   logic [4:0]  rd_M;
   logic        stall_M, mem_err, regWrite_W, dbg_state;
   logic [4:0]  rd_W;
   logic [31:0] result_W;

   int compared   = 0;
   int mismatched = 0;

   mem_stage_if bus ();

   mem_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .regWrite_M(regWrite_M), .memWrite_M(memWrite_M), .memRead_M(memRead_M),
      .resultScr_M(resultScr_M), .mode_M(mode_M), .ALUResult_M(ALUResult_M),
      .write_Data_M(write_Data_M), .imm_extended_M(imm_extended_M),
      .PC_target_M(PC_target_M), .pc4_M(pc4_M), .rd_M(rd_M),
      .dmem(bus.master),
      .stall_M(stall_M), .mem_err(mem_err), .regWrite_W(regWrite_W),
      .rd_W(rd_W), .result_W(result_W), .dbg_state(dbg_state)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      assert (obs === exp) else begin
         mismatched++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance to just after the next rising edge
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_instr(input logic rw, input logic mw, input logic mr,
                            input logic [2:0] scr, input logic [2:0] mode,
                            input logic [31:0] alu, input logic [31:0] wd,
                            input logic [4:0] rd, input logic ack,
                            input logic [31:0] rdata);
      regWrite_M   = rw;
      memWrite_M   = mw;
      memRead_M    = mr;
      resultScr_M  = scr;
      mode_M       = mode;
      ALUResult_M  = alu;
      write_Data_M = wd;
      rd_M         = rd;
      bus.ack      = ack;
      bus.rdata    = rdata;
   endtask

   task automatic nop();
      set_instr(1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 32'h0, 32'h0, 5'd0, 1'b0, 32'h0);
   endtask

   initial begin
      rst            = 1'b1;
      imm_extended_M = 32'h1234_5000;
      PC_target_M    = 32'h0000_1020;
      pc4_M          = 32'h0000_0024;
      // A load is presented during reset: outputs must still be zero
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b010, 32'h100, 32'h0, 5'd5, 1'b0, 32'h0);
      #2;
      chk("rst_req", {31'h0, bus.req}, 32'h0);
      chk("rst_stall", {31'h0, stall_M}, 32'h0);
      chk("rst_regwrite_w", {31'h0, regWrite_W}, 32'h0);
      chk("rst_result_w", result_W, 32'h0);
      chk("rst_rd_w", {27'h0, rd_W}, 32'h0);
      tick();
      tick();
      rst = 1'b0;

      // LW 0x100, ack in the same cycle
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b010, 32'h100, 32'h0, 5'd5, 1'b1, 32'hDEAD_BEEF);
      #2;
      chk("lw_req", {31'h0, bus.req}, 32'h1);
      chk("lw_we", {31'h0, bus.we}, 32'h0);
      chk("lw_addr", bus.addr, 32'h100);
      chk("lw_be", {28'h0, bus.be}, 32'hF);
      chk("lw_stall", {31'h0, stall_M}, 32'h0);
      tick();
      chk("lw_regwrite_w", {31'h0, regWrite_W}, 32'h1);
      chk("lw_rd_w", {27'h0, rd_W}, 32'd5);
      chk("lw_result_w", result_W, 32'hDEAD_BEEF);

      // LB / LBU at 0x103, LHU at 0x102 from 0x80FF0000
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b000, 32'h103, 32'h0, 5'd6, 1'b1, 32'h80FF_0000);
      #2;
      chk("lb_be", {28'h0, bus.be}, 32'h8);
      tick();
      chk("lb_result_w", result_W, 32'hFFFF_FF80);
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b100, 32'h103, 32'h0, 5'd7, 1'b1, 32'h80FF_0000);
      tick();
      chk("lbu_result_w", result_W, 32'h0000_0080);
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b101, 32'h102, 32'h0, 5'd8, 1'b1, 32'h80FF_0000);
      #2;
      chk("lhu_be", {28'h0, bus.be}, 32'hC);
      tick();
      chk("lhu_result_w", result_W, 32'h0000_80FF);
      chk("lhu_rd_w", {27'h0, rd_W}, 32'd8);
      // LH sign-extends the upper half
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b001, 32'h102, 32'h0, 5'd8, 1'b1, 32'h80FF_0000);
      tick();
      chk("lh_result_w", result_W, 32'hFFFF_80FF);

      // SB 0x102, ack arrives after three stalled cycles
      set_instr(1'b0, 1'b1, 1'b0, 3'b000, 3'b000, 32'h102, 32'h1234_5678, 5'd11, 1'b0, 32'h0);
      for (int i = 0; i < 3; i++) begin
         #2;
         chk("sb_req", {31'h0, bus.req}, 32'h1);
         chk("sb_we", {31'h0, bus.we}, 32'h1);
         chk("sb_addr", bus.addr, 32'h100);
         chk("sb_be", {28'h0, bus.be}, 32'h4);
         chk("sb_wdata", bus.wdata, 32'h7878_7878);
         chk("sb_stall", {31'h0, stall_M}, 32'h1);
         tick();
         chk("sb_bubble_regwrite", {31'h0, regWrite_W}, 32'h0);
         chk("sb_bubble_rd_hold", {27'h0, rd_W}, 32'd8);
         chk("sb_bubble_result_hold", result_W, 32'hFFFF_80FF);
      end
      bus.ack = 1'b1;
      #2;
      chk("sb_ack_stall", {31'h0, stall_M}, 32'h0);
      chk("sb_ack_req", {31'h0, bus.req}, 32'h1);
      chk("sb_ack_err", {31'h0, mem_err}, 32'h0);
      tick();
      chk("sb_done_regwrite", {31'h0, regWrite_W}, 32'h0);
      chk("sb_done_rd", {27'h0, rd_W}, 32'd11);
      chk("sb_done_result", result_W, 32'h102);

      // SH and SW store-lane formatting
      set_instr(1'b0, 1'b1, 1'b0, 3'b000, 3'b001, 32'h202, 32'hCAFE_BABE, 5'd0, 1'b1, 32'h0);
      #2;
      chk("sh_be", {28'h0, bus.be}, 32'hC);
      chk("sh_wdata", bus.wdata, 32'hBABE_BABE);
      tick();
      set_instr(1'b0, 1'b1, 1'b0, 3'b000, 3'b010, 32'h204, 32'hCAFE_BABE, 5'd0, 1'b1, 32'h0);
      #2;
      chk("sw_be", {28'h0, bus.be}, 32'hF);
      chk("sw_wdata", bus.wdata, 32'hCAFE_BABE);
      tick();

      // Misaligned LH at 0x101
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b001, 32'h101, 32'h0, 5'd9, 1'b1, 32'h1111_1111);
      #2;
      chk("mis_req", {31'h0, bus.req}, 32'h0);
      chk("mis_stall", {31'h0, stall_M}, 32'h0);
      chk("mis_err", {31'h0, mem_err}, 32'h1);
      tick();
      chk("mis_regwrite_w", {31'h0, regWrite_W}, 32'h0);
      nop();
      #2;
      chk("mis_err_one_pulse", {31'h0, mem_err}, 32'h0);
      tick();

      // LW that never gets an ack: 16 stalled cycles then abort
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b010, 32'h200, 32'h0, 5'd10, 1'b0, 32'h0);
      for (int i = 0; i < 16; i++) begin
         #2;
         chk("to_stall", {31'h0, stall_M}, 32'h1);
         chk("to_req", {31'h0, bus.req}, 32'h1);
         chk("to_no_err", {31'h0, mem_err}, 32'h0);
         tick();
         chk("to_bubble", {31'h0, regWrite_W}, 32'h0);
      end
      #2;
      chk("to_abort_stall", {31'h0, stall_M}, 32'h0);
      chk("to_abort_req", {31'h0, bus.req}, 32'h0);
      chk("to_abort_err", {31'h0, mem_err}, 32'h1);
      tick();
      chk("to_abort_regwrite", {31'h0, regWrite_W}, 32'h0);
      chk("to_abort_rd", {27'h0, rd_W}, 32'd10);

      // JAL then AUIPC, LUI and a reserved select code
      set_instr(1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 32'h0000_0400, 32'h0, 5'd1, 1'b0, 32'h0);
      #2;
      chk("jal_req", {31'h0, bus.req}, 32'h0);
      chk("jal_stall", {31'h0, stall_M}, 32'h0);
      chk("jal_err", {31'h0, mem_err}, 32'h0);
      tick();
      chk("jal_regwrite_w", {31'h0, regWrite_W}, 32'h1);
      chk("jal_rd_w", {27'h0, rd_W}, 32'd1);
      chk("jal_result_w", result_W, 32'h24);
      set_instr(1'b1, 1'b0, 1'b0, 3'b100, 3'b000, 32'h0000_0400, 32'h0, 5'd2, 1'b0, 32'h0);
      #2;
      chk("auipc_req", {31'h0, bus.req}, 32'h0);
      tick();
      chk("auipc_result_w", result_W, 32'h1020);
      set_instr(1'b1, 1'b0, 1'b0, 3'b011, 3'b000, 32'h0000_0400, 32'h0, 5'd3, 1'b0, 32'h0);
      tick();
      chk("lui_result_w", result_W, 32'h1234_5000);
      set_instr(1'b1, 1'b0, 1'b0, 3'b110, 3'b000, 32'h0000_0400, 32'h0, 5'd4, 1'b0, 32'h0);
      tick();
      chk("reserved_sel_result_w", result_W, 32'h400);

      // Reset asserted while waiting for an ack
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b010, 32'h300, 32'h0, 5'd12, 1'b0, 32'h0);
      #2;
      chk("rw_req_before", {31'h0, bus.req}, 32'h1);
      tick();
      tick();
      #2;
      chk("rw_wait_state", {31'h0, dbg_state}, 32'h1);
      rst = 1'b1;
      #1;
      chk("rw_req", {31'h0, bus.req}, 32'h0);
      chk("rw_stall", {31'h0, stall_M}, 32'h0);
      chk("rw_be", {28'h0, bus.be}, 32'h0);
      chk("rw_addr", bus.addr, 32'h0);
      chk("rw_regwrite_w", {31'h0, regWrite_W}, 32'h0);
      chk("rw_rd_w", {27'h0, rd_W}, 32'h0);
      chk("rw_result_w", result_W, 32'h0);
      chk("rw_state", {31'h0, dbg_state}, 32'h0);
      tick();
      nop();
      rst = 1'b0;
      tick();

      // Normal load after reset
      set_instr(1'b1, 1'b0, 1'b1, 3'b001, 3'b010, 32'h104, 32'h0, 5'd13, 1'b1, 32'h0BAD_F00D);
      #2;
      chk("post_rst_stall", {31'h0, stall_M}, 32'h0);
      tick();
      chk("post_rst_regwrite_w", {31'h0, regWrite_W}, 32'h1);
      chk("post_rst_result_w", result_W, 32'h0BAD_F00D);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

   // Safety net so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog: observed no completion expected completion");
      $fatal(1, "watchdog expired");
   end

endmodule
